// File: rtl/uart_rx_deser_if.sv
// Receive-side bus between the UART deserializer (master) and the RX FIFO / status logic (slave).
interface uart_rx_deser_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] wdata_o;
   logic                 we_o;
   logic                 full_i;
   logic                 frame_err_o;
   logic                 parity_err_o;
   logic                 overrun_o;
   logic                 busy_o;

   modport master (output wdata_o, we_o, frame_err_o, parity_err_o, overrun_o, busy_o,
                   input  full_i);
   modport slave  (input  wdata_o, we_o, frame_err_o, parity_err_o, overrun_o, busy_o,
                   output full_i);
endinterface

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 16x oversampling, start/data/parity/stop framing, single-cycle
// FIFO write strobe and one-cycle error pulses (frame, parity, overrun).
module uart_rx_deser #(
   parameter int BAUD_DIV   = 27,
   parameter int DATA_BITS  = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            rx_i,
   uart_rx_deser_if.master bus
);
   localparam int TW = $clog2(BAUD_DIV);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] TICK_LAST = TW'(BAUD_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
   localparam logic          ODD       = (PARITY_ODD != 0);

   typedef enum logic [2:0] {
      ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
   } state_t;

   logic                 r_sync1, r_sync2, r_rx_prev;
   logic                 w_rx_s, w_tick, w_fall, w_start_smp, w_bit_smp;
   state_t               r_state;
   logic [TW-1:0]        r_tick_cnt;
   logic [3:0]           r_smp_cnt;
   logic [BW-1:0]        r_bit_cnt;
   logic [DATA_BITS-1:0] r_shift, r_wdata;
   logic                 r_perr, r_we, r_ferr, r_perr_pulse, r_ovr;

   // Idle-high line: synchronizer and edge history reset to 1 so reset release never looks like a start.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync1   <= 1'b1;
         r_sync2   <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx_i;
         r_sync2   <= r_sync1;
         r_rx_prev <= r_sync2;
      end
   end

   assign w_rx_s      = r_sync2;
   assign w_fall      = r_rx_prev & ~w_rx_s;
   assign w_tick      = (r_tick_cnt == TICK_LAST);
   assign w_start_smp = w_tick && (r_smp_cnt == 4'd7);
   assign w_bit_smp   = w_tick && (r_smp_cnt == 4'd15);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state      <= ST_IDLE;
         r_tick_cnt   <= '0;
         r_smp_cnt    <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_wdata      <= '0;
         r_perr       <= 1'b0;
         r_we         <= 1'b0;
         r_ferr       <= 1'b0;
         r_perr_pulse <= 1'b0;
         r_ovr        <= 1'b0;
      end else begin
         r_we         <= 1'b0;
         r_ferr       <= 1'b0;
         r_perr_pulse <= 1'b0;
         r_ovr        <= 1'b0;
         r_tick_cnt   <= w_tick ? '0 : r_tick_cnt + 1'b1;
         if (w_tick) r_smp_cnt <= r_smp_cnt + 1'b1;

         case (r_state)
            ST_IDLE: begin
               if (w_fall) begin
                  r_state    <= ST_START;
                  r_tick_cnt <= '0;
                  r_smp_cnt  <= '0;
               end
            end
            ST_START: begin
               // Mid start bit: from here on every 16th tick lands mid-bit.
               if (w_start_smp) begin
                  r_smp_cnt <= '0;
                  r_bit_cnt <= '0;
                  r_perr    <= 1'b0;
                  r_state   <= w_rx_s ? ST_IDLE : ST_DATA;
               end
            end
            ST_DATA: begin
               if (w_bit_smp) begin
                  r_shift   <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                  r_bit_cnt <= r_bit_cnt + 1'b1;
                  if (r_bit_cnt == BIT_LAST)
                     r_state <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
               end
            end
            ST_PARITY: begin
               if (w_bit_smp) begin
                  r_perr  <= ((^r_shift) ^ w_rx_s) != ODD;
                  r_state <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (w_bit_smp) begin
                  if (!w_rx_s) begin
                     r_ferr  <= 1'b1;
                     r_state <= ST_BREAK;
                  end else begin
                     r_state <= ST_IDLE;
                     if (r_perr)          r_perr_pulse <= 1'b1;
                     else if (bus.full_i) r_ovr        <= 1'b1;
                     else begin
                        r_wdata <= r_shift;
                        r_we    <= 1'b1;
                     end
                  end
               end
            end
            ST_BREAK: begin
               if (w_rx_s) r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.wdata_o      = r_wdata;
   assign bus.we_o         = r_we;
   assign bus.frame_err_o  = r_ferr;
   assign bus.parity_err_o = r_perr_pulse;
   assign bus.overrun_o    = r_ovr;
   assign bus.busy_o       = (r_state != ST_IDLE);
endmodule
